// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX joystick-port mouse reader.
package msx_mouse_pkg;

  // Poll sequencer states. One poll visits TOGGLE/SETTLE/SAMPLE once per
  // nibble and then DONE once.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOGGLE = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Nibbles per poll: X high, X low, Y high, Y low.
  localparam int NIBBLES = 4;

  // Port pin positions inside the 6-bit pin vector.
  localparam int NIB_LSB = 0;
  localparam int BTN1    = 4;
  localparam int BTN2    = 5;

  // Data nibble carried on the low four pins.
  function automatic logic [3:0] pin_nibble(input logic [5:0] pins);
    return pins[NIB_LSB +: 4];
  endfunction

  // Buttons are active-low on the port; return them active-high as
  // {button 2, button 1}.
  function automatic logic [1:0] pin_buttons(input logic [5:0] pins);
    return ~{pins[BTN2], pins[BTN1]};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-bit two-stage synchronizer for asynchronous inputs, with a selectable
// reset value so idle-high lines do not glitch low out of reset.
module sync_ff #(
  parameter int             N       = 6,
  parameter logic [N-1:0]   RST_VAL = '1
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/msx_mouse_reader.sv
// Host-side reader for the MSX joystick-port mouse. Each poll toggles the
// strobe four times, waits SETTLE_CYC cycles after every edge, samples one
// nibble per edge (X hi, X lo, Y hi, Y lo) and publishes signed 8-bit deltas
// plus the two buttons.
//
// Output handshake: valid is a single-cycle pulse with no back-pressure;
// dx/dy/btn change only in the cycle valid is high and hold until the next
// pulse. busy is high from the cycle the first strobe edge appears through
// the valid cycle, and is low the cycle after.
module msx_mouse_reader
  import msx_mouse_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 860,
  parameter int unsigned POLL_CYC   = 358000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] pin_in,
  output logic       strobe,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       busy
);

  localparam int POLL_W = $clog2(POLL_CYC);
  localparam int SET_W  = $clog2(SETTLE_CYC);
  localparam int IDX_W  = $clog2(NIBBLES);

  localparam logic [POLL_W-1:0] POLL_RELOAD   = POLL_W'(POLL_CYC - 1);
  localparam logic [SET_W-1:0]  SETTLE_RELOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NIBBLES - 1);

  state_t            state;
  state_t            state_next;
  logic              poll_start;

  logic [5:0]        pins_sync;
  logic [POLL_W-1:0] poll_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       sr;
  logic [1:0]        btn_cap;

  // Port pins are asynchronous to clk_sys; idle level of every pin is high.
  sync_ff #(
    .N       (6),
    .RST_VAL (6'h3F)
  ) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (pin_in),
    .q       (pins_sync)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; poll_start marks the cycle a poll is committed to.
  always_comb begin
    state_next = state;
    poll_start = 1'b0;
    case (state)
      IDLE: begin
        if (poll_cnt == '0 && enable) begin
          state_next = TOGGLE;
          poll_start = 1'b1;
        end
      end
      TOGGLE: state_next = SETTLE;
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: state_next = (idx == LAST_IDX) ? DONE : TOGGLE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Poll interval counter: free-runs in every state so poll starts stay
  // POLL_CYC apart; it parks at zero while enable holds off the next poll.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      poll_cnt <= POLL_RELOAD;
    end else if (poll_start) begin
      poll_cnt <= POLL_RELOAD;
    end else if (poll_cnt != '0) begin
      poll_cnt <= poll_cnt - 1'b1;
    end
  end

  // Settle counter: loaded on each strobe toggle, so SETTLE dwells exactly
  // SETTLE_CYC cycles before the nibble is sampled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (state == TOGGLE) begin
      settle_cnt <= SETTLE_RELOAD;
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Strobe and busy. Four toggles per poll bring strobe back to its
  // pre-poll level; a mid-poll reset forces it low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      strobe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE:    busy   <= 1'b0;
        TOGGLE: begin
          strobe <= ~strobe;
          busy   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Nibble index and shift register: nibbles enter MSB-first so the first
  // sample ends up in sr[15:12]. Buttons are taken with the last nibble.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idx     <= '0;
      sr      <= '0;
      btn_cap <= '0;
    end else if (poll_start) begin
      idx <= '0;
    end else if (state == SAMPLE) begin
      sr  <= {sr[11:0], pin_nibble(pins_sync)};
      idx <= idx + 1'b1;
      if (idx == LAST_IDX) begin
        btn_cap <= pin_buttons(pins_sync);
      end
    end
  end

  // Result publication: dx/dy/btn update together with the valid pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dx    <= '0;
      dy    <= '0;
      btn   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == DONE) begin
        dx    <= sr[15:8];
        dy    <= sr[7:0];
        btn   <= btn_cap;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Bench for msx_mouse_reader: two instances (settle 4 and settle 3), each
// driven by a behavioural mouse that presents the next nibble a programmable
// number of cycles after every strobe edge.
module tb_msx_mouse_reader;

  localparam int S_A = 4;
  localparam int P_A = 60;
  localparam int S_B = 3;
  localparam int P_B = 40;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset    = 1'b1;
  logic enable   = 1'b0;
  logic enable_b = 1'b0;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic [3:0] nib_a  = 4'h0;
  logic [1:0] bpin_a = 2'b11;
  logic       strobe_a, valid_a, busy_a;
  logic [7:0] dx_a, dy_a;
  logic [1:0] btn_a;

  msx_mouse_reader #(.SETTLE_CYC(S_A), .POLL_CYC(P_A)) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (enable),
    .pin_in  ({bpin_a, nib_a}),
    .strobe  (strobe_a),
    .dx      (dx_a),
    .dy      (dy_a),
    .btn     (btn_a),
    .valid   (valid_a),
    .busy    (busy_a)
  );

  // ---------------- DUT B ----------------
  logic [3:0] nib_b  = 4'h0;
  logic [1:0] bpin_b = 2'b11;
  logic       strobe_b, valid_b, busy_b;
  logic [7:0] dx_b, dy_b;
  logic [1:0] btn_b;

  msx_mouse_reader #(.SETTLE_CYC(S_B), .POLL_CYC(P_B)) u_dut_b (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (enable_b),
    .pin_in  ({bpin_b, nib_b}),
    .strobe  (strobe_b),
    .dx      (dx_b),
    .dy      (dy_b),
    .btn     (btn_b),
    .valid   (valid_b),
    .busy    (busy_b)
  );

  // ---------------- mouse models ----------------
  logic [7:0] x_a = 8'h00, y_a = 8'h00, x_b = 8'h00, y_b = 8'h00;
  int mdel_a = 1;
  localparam int MDEL_B = 2;

  function automatic logic [3:0] pick(input logic [7:0] x, input logic [7:0] y, input int i);
    logic [15:0] w;
    w = {x, y};
    return w[15 - 4*i -: 4];
  endfunction

  int   ma_idx = 0, ma_cnt = 0;
  logic ma_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      ma_idx  = 0;
      ma_cnt  = 0;
      ma_prev = strobe_a;
    end else begin
      if (strobe_a != ma_prev) begin
        ma_prev = strobe_a;
        ma_cnt  = mdel_a;
      end
      if (ma_cnt != 0) begin
        ma_cnt--;
        if (ma_cnt == 0) begin
          nib_a  = pick(x_a, y_a, ma_idx);
          ma_idx = (ma_idx + 1) % 4;
        end
      end
    end
  end

  int   mb_idx = 0, mb_cnt = 0;
  logic mb_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      mb_idx  = 0;
      mb_cnt  = 0;
      mb_prev = strobe_b;
    end else begin
      if (strobe_b != mb_prev) begin
        mb_prev = strobe_b;
        mb_cnt  = MDEL_B;
      end
      if (mb_cnt != 0) begin
        mb_cnt--;
        if (mb_cnt == 0) begin
          nib_b  = pick(x_b, y_b, mb_idx);
          mb_idx = (mb_idx + 1) % 4;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  logic [17:0] exp_qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int   edge_cnt = 0;
  int   edge_cnt_b = 0;
  int   edge_cyc[$];
  int   valid_cyc[$];
  int   busy_fall[$];
  logic mp_strobe = 1'b0, mp_busy = 1'b0, mp_strobe_b = 1'b0;

  // Monitor A: edge/busy timing log plus result comparison on every valid.
  always @(negedge clk_sys) begin
    logic [17:0] e;
    if (!reset) begin
      if (strobe_a != mp_strobe) begin
        edge_cnt++;
        edge_cyc.push_back(cyc);
      end
      if (mp_busy && !busy_a) busy_fall.push_back(cyc);
      if (valid_a) begin
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid_a: got %h, expected no result", {btn_a, dx_a, dy_a});
        end else begin
          e = exp_q.pop_front();
          check("result_a", {14'd0, btn_a, dx_a, dy_a}, {14'd0, e});
        end
        check("strobe_at_valid_a", {31'd0, strobe_a}, 32'd0);
      end
    end
    mp_strobe = strobe_a;
    mp_busy   = busy_a;
  end

  // Monitor B: result comparison only.
  always @(negedge clk_sys) begin
    logic [17:0] e;
    if (!reset) begin
      if (strobe_b != mp_strobe_b) edge_cnt_b++;
      if (valid_b) begin
        if (exp_qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid_b: got %h, expected no result", {btn_b, dx_b, dy_b});
        end else begin
          e = exp_qb.pop_front();
          check("result_b", {14'd0, btn_b, dx_b, dy_b}, {14'd0, e});
        end
      end
    end
    mp_strobe_b = strobe_b;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_edges(input int target, input int limit);
    int k;
    k = 0;
    while (edge_cnt < target && k < limit) begin
      step();
      k++;
    end
    if (edge_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_edges: got %0d edges, expected %0d", edge_cnt, target);
    end
  endtask

  task automatic wait_drain_a(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_valid_a: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_drain_b(input int limit);
    int k;
    k = 0;
    while (exp_qb.size() != 0 && k < limit) begin
      step();
      k++;
    end
    if (exp_qb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_valid_b: got %0d pending, expected 0", exp_qb.size());
      exp_qb.delete();
    end
  endtask

  task automatic clear_logs();
    edge_cyc.delete();
    valid_cyc.delete();
    busy_fall.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, b, c, k;

    // Reset state.
    repeat (3) step();
    check("rst_strobe", {31'd0, strobe_a}, 32'd0);
    check("rst_dx",     {24'd0, dx_a},     32'd0);
    check("rst_dy",     {24'd0, dy_a},     32'd0);
    check("rst_btn",    {30'd0, btn_a},    32'd0);
    check("rst_valid",  {31'd0, valid_a},  32'd0);
    check("rst_busy",   {31'd0, busy_a},   32'd0);
    check("rst_strobe_b", {31'd0, strobe_b}, 32'd0);

    // Basic poll plus steady-enable spacing: three polls, 60 cycles apart.
    x_a = 8'hFD; y_a = 8'h05; bpin_a = 2'b10;
    repeat (3) exp_q.push_back({2'b01, 8'hFD, 8'h05});
    clear_logs();
    reset  = 1'b0;
    enable = 1'b1;
    r = cyc;
    wait_drain_a(400);
    enable = 1'b0;
    check("edges_3_polls", edge_cnt, 12);
    // Reset releases in cycle r: counter hits 0 at r+59, TOGGLE at r+60,
    // strobe edge visible at r+61.
    check("first_poll_start", edge_cyc[0] - r, 61);
    // TOGGLE is one cycle before the visible edge, so 25-1 cycles edge->valid.
    check("latency", valid_cyc[0] - edge_cyc[0], 24);
    check("poll_gap_1", edge_cyc[4] - edge_cyc[0], 60);
    check("poll_gap_2", edge_cyc[8] - edge_cyc[4], 60);
    check("valid_gap_1", valid_cyc[1] - valid_cyc[0], 60);
    check("valid_gap_2", valid_cyc[2] - valid_cyc[1], 60);
    check("busy_low", edge_cyc[4] - busy_fall[0], 35);

    // Drop enable after the 2nd strobe edge: poll still completes.
    x_a = 8'h3C; y_a = 8'hA7; bpin_a = 2'b01;
    exp_q.push_back({2'b10, 8'h3C, 8'hA7});
    b = edge_cnt;
    enable = 1'b1;
    wait_edges(b + 2, 200);
    enable = 1'b0;
    wait_drain_a(200);
    repeat (150) step();
    check("no_edges_while_disabled", edge_cnt, b + 4);
    // Counter is parked at 0: raising enable starts the poll in this cycle.
    exp_q.push_back({2'b10, 8'h3C, 8'hA7});
    clear_logs();
    enable = 1'b1;
    c = cyc;
    wait_edges(b + 5, 10);
    check("restart_immediate", edge_cyc[0] - c, 2);
    enable = 1'b0;
    wait_drain_a(100);

    // Reset between the 3rd SAMPLE and the 4th TOGGLE.
    x_a = 8'h21; y_a = 8'hF0; bpin_a = 2'b01;
    b = edge_cnt;
    enable = 1'b1;
    wait_edges(b + 3, 200);
    repeat (5) step();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) step();
    check("midrst_strobe", {31'd0, strobe_a}, 32'd0);
    check("midrst_busy",   {31'd0, busy_a},   32'd0);
    check("midrst_dx",     {24'd0, dx_a},     32'd0);
    check("midrst_dy",     {24'd0, dy_a},     32'd0);
    check("midrst_valid",  {31'd0, valid_a},  32'd0);
    clear_logs();
    exp_q.push_back({2'b10, 8'h21, 8'hF0});
    reset  = 1'b0;
    enable = 1'b1;
    r = cyc;
    b = edge_cnt;
    wait_edges(b + 1, 100);
    check("post_reset_start", edge_cyc[0] - r, 61);
    enable = 1'b0;
    wait_drain_a(100);

    // Late nibble change (+3 cycles) inside a 4-cycle settle window.
    mdel_a = 3;
    x_a = 8'hC3; y_a = 8'h5A; bpin_a = 2'b11;
    exp_q.push_back({2'b00, 8'hC3, 8'h5A});
    b = edge_cnt;
    enable = 1'b1;
    wait_edges(b + 1, 100);
    enable = 1'b0;
    wait_drain_a(100);

    // Back-to-back polls with extreme deltas and both buttons pressed.
    mdel_a = 1;
    x_a = 8'h80; y_a = 8'h7F; bpin_a = 2'b00;
    clear_logs();
    repeat (2) exp_q.push_back({2'b11, 8'h80, 8'h7F});
    b = edge_cnt;
    enable = 1'b1;
    wait_edges(b + 5, 200);
    enable = 1'b0;
    wait_drain_a(100);
    check("b2b_valid_gap", valid_cyc[1] - valid_cyc[0], 60);

    // Settle of 3 with the nibble changing 2 cycles after each edge.
    x_b = 8'hE1; y_b = 8'h4B; bpin_b = 2'b10;
    exp_qb.push_back({2'b01, 8'hE1, 8'h4B});
    enable_b = 1'b1;
    k = 0;
    while (edge_cnt_b < 1 && k < 100) begin
      step();
      k++;
    end
    enable_b = 1'b0;
    wait_drain_b(100);

    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
